// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: issues one ROM read at a time and queues the
// returned {pc, inst} pairs in a small FIFO for decode, with branch flush.
module inst_fetch_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    input  logic          ce,
    output logic          fetch_stall,
    output logic          rom_req,
    output logic [AW-1:0] rom_addr,
    input  logic          rom_ack,
    input  logic [DW-1:0] rom_data,
    input  logic          flush,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [AW-1:0] id_pc,
    output logic [DW-1:0] id_inst
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_req;
    logic [AW-1:0]   r_addr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_mem_pc   [DEPTH];
    logic [DW-1:0]   r_mem_inst [DEPTH];

    logic w_can_issue;
    logic w_issue;
    logic w_push;
    logic w_pop;

    // Only one fetch outstanding, so checking count at issue reserves its slot.
    assign w_can_issue = (r_state == S_IDLE) && (r_count < CW'(DEPTH)) && !flush;
    assign w_issue     = ce && w_can_issue;
    assign w_push      = (r_state == S_WAIT) && rom_ack && !flush;
    assign w_pop       = (r_count != '0) && id_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_issue) w_next = S_WAIT;
            S_WAIT: begin
                if (rom_ack)    w_next = S_IDLE;
                else if (flush) w_next = S_DROP;
            end
            S_DROP: if (rom_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_stall = ce && !w_can_issue;
        id_valid    = (r_count != '0);
        id_pc       = id_valid ? r_mem_pc[r_rd_ptr]   : '0;
        id_inst     = id_valid ? r_mem_inst[r_rd_ptr] : '0;
    end

    // The request is never withdrawn before its ack, even across a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req  <= 1'b0;
            r_addr <= '0;
        end else if (w_issue) begin
            r_req  <= 1'b1;
            r_addr <= pc;
        end else if (r_state != S_IDLE && rom_ack) begin
            r_req  <= 1'b0;
        end
    end

    assign rom_req  = r_req;
    assign rom_addr = r_addr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem_pc[r_wr_ptr]   <= r_addr;
            r_mem_inst[r_wr_ptr] <= rom_data;
        end
    end
endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf: a per-cycle vector table plus hand
// sequences for push/pop wrap and reset during an outstanding request.
module tb_inst_fetch_buf;
    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        ce;
    logic        fetch_stall;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int checks = 0;
    int errors = 0;

    inst_fetch_buf #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .pc(pc), .ce(ce), .fetch_stall(fetch_stall),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
        .rom_data(rom_data), .flush(flush), .id_valid(id_valid),
        .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] data;
        logic        flush;
        logic        rdy;
        logic        e_stall;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    function automatic vec_t mk(logic c, logic [31:0] p, logic a, logic [31:0] d,
                                logic f, logic r, logic es, logic eq,
                                logic [31:0] ea, logic ev, logic [31:0] ep,
                                logic [31:0] ei);
        vec_t v;
        v.ce = c; v.pc = p; v.ack = a; v.data = d; v.flush = f; v.rdy = r;
        v.e_stall = es; v.e_req = eq; v.e_addr = ea; v.e_vld = ev;
        v.e_pc = ep; v.e_inst = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs on the falling edge and let comb outputs settle.
    task automatic cyc(input logic r, input logic c, input logic [31:0] p,
                       input logic a, input logic [31:0] d, input logic f,
                       input logic rd);
        @(negedge clk);
        rst = r; ce = c; pc = p; rom_ack = a; rom_data = d; flush = f; id_ready = rd;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic es, input logic eq,
                           input logic [31:0] ea, input logic ev,
                           input logic [31:0] ep, input logic [31:0] ei);
        chk({tag, ".stall"}, {31'b0, fetch_stall}, {31'b0, es});
        chk({tag, ".req"},   {31'b0, rom_req},     {31'b0, eq});
        chk({tag, ".addr"},  rom_addr, ea);
        chk({tag, ".vld"},   {31'b0, id_valid},    {31'b0, ev});
        chk({tag, ".pc"},    id_pc, ep);
        chk({tag, ".inst"},  id_inst, ei);
    endtask

    function automatic logic [31:0] fd(input logic [31:0] p);
        return 32'hA5A5_0000 | p;
    endfunction

    vec_t tbl[25];

    initial begin
        rst = 1'b1; ce = 1'b0; pc = '0; rom_ack = 1'b0; rom_data = '0;
        flush = 1'b0; id_ready = 1'b0;

        //            ce  pc      ack data          fl rdy  stl req addr    vld idpc    idinst
        tbl[0]  = mk(0, 32'h0,  0, 32'h0,        0, 0,   0, 0, 32'h0,  0, 32'h0, 32'h0);
        tbl[1]  = mk(1, 32'h0,  0, 32'h0,        0, 0,   0, 0, 32'h0,  0, 32'h0, 32'h0);
        tbl[2]  = mk(1, 32'h4,  0, 32'h0,        0, 0,   1, 1, 32'h0,  0, 32'h0, 32'h0);
        tbl[3]  = mk(1, 32'h4,  0, 32'h0,        0, 0,   1, 1, 32'h0,  0, 32'h0, 32'h0);
        tbl[4]  = mk(1, 32'h4,  1, 32'h3C010101, 0, 0,   1, 1, 32'h0,  0, 32'h0, 32'h0);
        tbl[5]  = mk(0, 32'h0,  0, 32'h0,        0, 1,   0, 0, 32'h0,  1, 32'h0, 32'h3C010101);
        tbl[6]  = mk(0, 32'h0,  0, 32'h0,        0, 0,   0, 0, 32'h0,  0, 32'h0, 32'h0);
        // fill to DEPTH with ack latency 1 and decode not ready
        tbl[7]  = mk(1, 32'h0,  0, 32'h0,        0, 0,   0, 0, 32'h0,  0, 32'h0, 32'h0);
        tbl[8]  = mk(1, 32'h4,  1, 32'hD0,       0, 0,   1, 1, 32'h0,  0, 32'h0, 32'h0);
        tbl[9]  = mk(1, 32'h4,  0, 32'h0,        0, 0,   0, 0, 32'h0,  1, 32'h0, 32'hD0);
        tbl[10] = mk(1, 32'h8,  1, 32'hD1,       0, 0,   1, 1, 32'h4,  1, 32'h0, 32'hD0);
        tbl[11] = mk(1, 32'h8,  0, 32'h0,        0, 0,   0, 0, 32'h4,  1, 32'h0, 32'hD0);
        tbl[12] = mk(1, 32'hC,  1, 32'hD2,       0, 0,   1, 1, 32'h8,  1, 32'h0, 32'hD0);
        tbl[13] = mk(1, 32'hC,  0, 32'h0,        0, 0,   0, 0, 32'h8,  1, 32'h0, 32'hD0);
        tbl[14] = mk(1, 32'h10, 1, 32'hD3,       0, 0,   1, 1, 32'hC,  1, 32'h0, 32'hD0);
        tbl[15] = mk(1, 32'h10, 0, 32'h0,        0, 0,   1, 0, 32'hC,  1, 32'h0, 32'hD0);
        tbl[16] = mk(1, 32'h10, 0, 32'h0,        0, 1,   1, 0, 32'hC,  1, 32'h0, 32'hD0);
        tbl[17] = mk(1, 32'h10, 0, 32'h0,        0, 0,   0, 0, 32'hC,  1, 32'h4, 32'hD1);
        // flush in first WAIT cycle with three entries queued
        tbl[18] = mk(1, 32'h14, 0, 32'h0,        1, 0,   1, 1, 32'h10, 1, 32'h4, 32'hD1);
        tbl[19] = mk(1, 32'h14, 0, 32'h0,        0, 0,   1, 1, 32'h10, 0, 32'h0, 32'h0);
        tbl[20] = mk(1, 32'h14, 1, 32'hDEAD,     0, 0,   1, 1, 32'h10, 0, 32'h0, 32'h0);
        tbl[21] = mk(1, 32'h14, 0, 32'h0,        0, 0,   0, 0, 32'h10, 0, 32'h0, 32'h0);
        // flush together with the ack
        tbl[22] = mk(1, 32'h18, 1, 32'hBEEF,     1, 0,   1, 1, 32'h14, 0, 32'h0, 32'h0);
        tbl[23] = mk(1, 32'h18, 0, 32'h0,        1, 0,   1, 0, 32'h14, 0, 32'h0, 32'h0);
        tbl[24] = mk(0, 32'h0,  0, 32'h0,        0, 0,   0, 0, 32'h14, 0, 32'h0, 32'h0);

        repeat (2) @(posedge clk);

        for (int i = 0; i < 25; i++) begin
            cyc(1'b0, tbl[i].ce, tbl[i].pc, tbl[i].ack, tbl[i].data, tbl[i].flush, tbl[i].rdy);
            chk_out($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_req, tbl[i].e_addr,
                    tbl[i].e_vld, tbl[i].e_pc, tbl[i].e_inst);
        end

        // two entries queued, then push and pop together across pointer wrap
        cyc(0, 1, 32'h0, 0, 32'h0, 0, 0);
        cyc(0, 0, 32'h0, 1, fd(32'h0), 0, 0);
        cyc(0, 1, 32'h4, 0, 32'h0, 0, 0);
        cyc(0, 0, 32'h0, 1, fd(32'h4), 0, 0);
        for (int k = 2; k < 8; k++) begin
            cyc(0, 1, 32'(4 * k), 0, 32'h0, 0, 0);
            chk($sformatf("wrap%0d.issue_stall", k), {31'b0, fetch_stall}, 32'h0);
            chk($sformatf("wrap%0d.head_pc", k), id_pc, 32'(4 * (k - 2)));
            cyc(0, 0, 32'h0, 1, fd(32'(4 * k)), 0, 1);
            chk($sformatf("wrap%0d.pop_pc", k), id_pc, 32'(4 * (k - 2)));
            chk($sformatf("wrap%0d.pop_inst", k), id_inst, fd(32'(4 * (k - 2))));
        end
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 1);
        chk("drain0.vld", {31'b0, id_valid}, 32'h1);
        chk("drain0.pc", id_pc, 32'h18);
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 1);
        chk("drain1.pc", id_pc, 32'h1C);
        chk("drain1.inst", id_inst, fd(32'h1C));
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0);
        chk("drain2.vld", {31'b0, id_valid}, 32'h0);

        // reset while a request is outstanding and one entry is queued
        cyc(0, 1, 32'h30, 0, 32'h0, 0, 0);
        cyc(0, 0, 32'h0, 1, 32'h1111, 0, 0);
        cyc(0, 1, 32'h40, 0, 32'h0, 0, 0);
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0);
        chk_out("prerst", 0, 1, 32'h40, 1, 32'h30, 32'h1111);
        cyc(1, 0, 32'h0, 1, 32'h2222, 0, 0);
        cyc(0, 0, 32'h0, 1, 32'h3333, 0, 0);
        chk_out("postrst", 0, 0, 32'h0, 0, 32'h0, 32'h0);
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0);
        chk_out("lateack", 0, 0, 32'h0, 0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_fetch_buf.md
Name: inst_fetch_buf

Overview:
Fetch stage directly downstream of the PC register. It consumes the pc/ce pair and issues one instruction-ROM read at a time over a req/ack handshake. Returned {pc, inst} pairs go into a small FIFO, which feeds the decode stage over a valid/ready interface. It provides a flush for branch redirects and a stall back to the PC source when it cannot accept a new address.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
AW, 32, instruction address width (matches INST_ADDR_BUS)
DW, 32, instruction word width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high (RST_ENABLE); sampled on the rising edge of clk
pc  in  AW  fetch address from the PC register
ce  in  1  PC-valid / chip enable from the PC register (1 = pc is a fetch request)
fetch_stall  out  1  combinational; 1 = address not accepted this cycle, the PC source must hold pc
rom_req  out  1  registered ROM read request
rom_addr  out  AW  registered ROM address, stable while rom_req=1
rom_ack  in  1  ROM response strobe; rom_data is valid in the same cycle
rom_data  in  DW  instruction word
flush  in  1  discard all buffered and in-flight fetches
id_valid  out  1  FIFO head is valid
id_ready  in  1  decode accepts the head
id_pc  out  AW  head pc; 0 when empty
id_inst  out  DW  head instruction; 0 when empty

Behaviour:
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response kept.
  - DROP: request outstanding, response to be discarded.
- Reset (rst=1 at edge), any state: state=IDLE, FIFO count=0, rd/wr pointers=0, rom_req=0, rom_addr=0. id_valid=0 and id_pc/id_inst=0 follow from the empty FIFO. Reset overrides flush and rom_ack; an ack arriving in the reset cycle is lost.
- can_issue = (state==IDLE) & (count<DEPTH) & ~flush.
- fetch_stall = ce & ~can_issue. When ce=0, fetch_stall=0.
- Issue: at an edge where ce & can_issue:
  - rom_addr<=pc, rom_req<=1, state->WAIT.
  - The PC source advances after this edge.
- WAIT:
  - rom_req is held at 1 and rom_addr is held stable until rom_ack=1.
  - On an ack edge without flush: push {rom_addr, rom_data} at wr_ptr, rom_req<=0, state->IDLE.
  - Minimum ack latency is 1 cycle after rom_req rises. Peak throughput is one fetch per 2 cycles.
- Flush in WAIT:
  - If rom_ack=1 in the same cycle: data discarded, rom_req<=0, state->IDLE.
  - Otherwise: state->DROP with rom_req held at 1.
- DROP: rom_req held until rom_ack; the ack data is discarded; rom_req<=0, state->IDLE. A further flush while in DROP has no extra effect.
- The ROM handshake is never abandoned: rom_req drops only after an ack or a reset.
- FIFO:
  - Pop on id_valid & id_ready (rd_ptr+1, wraps mod DEPTH).
  - Push advances wr_ptr (wraps mod DEPTH).
  - Push and pop in the same cycle leave count unchanged.
  - A push can never overflow: the issue gate reserves the slot.
- Outputs: id_valid = (count!=0). id_pc/id_inst are driven combinationally from the head entry, or 0 when empty.
- Flush edge:
  - count<=0, rd_ptr<=0, wr_ptr<=0.
  - Any pop or push in that cycle is cancelled.
  - id_valid is 0 on the next cycle.
  - No issue occurs in the flush cycle.
- Ordering: instructions reach ID in issue order; each accepted pc produces exactly one entry unless flushed.

Test Plan:
- Reset: assert rst with rom_req=1 in WAIT -> next cycle rom_req=0, id_valid=0, id_pc=0, state IDLE; no push when the late ack arrives.
- Single fetch: pc=0x0, ce=1, ack 3 cycles after rom_req rises with data 0x3C010101 -> rom_addr=0x0 throughout, then id_valid=1, id_pc=0x0, id_inst=0x3C010101; with id_ready=1, popped next edge.
- Fill: ack latency 1, id_ready=0, pcs 0x0,0x4,0x8,0xC -> four entries, then fetch_stall=1 with ce=1 and no rom_req; one id_ready pulse pops 0x0 and issue of 0x10 resumes.
- Simultaneous push/pop: count=2, ack and id_ready in the same cycle -> count stays 2, order preserved across pointer wrap (pcs 0x0..0x1C through DEPTH=4).
- Flush mid-wait: flush in the first WAIT cycle with 3 entries queued -> id_valid=0 next cycle, state DROP, rom_req stays 1 until ack, ack data not pushed, next issue only after IDLE.
- Flush on ack cycle: flush and rom_ack together -> nothing pushed, rom_req=0 and state IDLE next cycle, FIFO empty.
